// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage with a skid buffer.
// The main entry drives the outputs. The skid entry catches the one beat that
// arrives while main is stalled. in_ready comes from a register only, so there
// is no combinational path from out_ready to in_ready.
// Optional feature macro: PIPE_STAGE_STALL_CNT_EN adds a 32-bit stall_cnt output.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned EXC_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              bd;
    logic              valid;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  state_e state;
  logic   accept;
  logic   drain;

  assign in_entry  = {in_data, in_exc, in_bd, 1'b1};
  assign in_ready  = !skid_q.valid;
  assign out_valid = main_q.valid;
  assign out_data  = main_q.data;
  assign out_exc   = main_q.exc;
  assign out_bd    = main_q.bd;
  assign occupancy = {1'b0, main_q.valid} + {1'b0, skid_q.valid};
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // Decode the occupancy state from the two valid bits. Skid is only ever
  // filled while main is valid, so skid-only is unreachable.
  always_comb begin
    if (skid_q.valid) begin
      state = StFull;
    end else if (main_q.valid) begin
      state = StOne;
    end else begin
      state = StEmpty;
    end
  end

  // Next-state logic for both entries. Flush overrides accept and drain.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = '0;
      skid_d = '0;
    end else begin
      unique case (state)
        StEmpty: begin
          if (accept) main_d = in_entry;
        end
        StOne: begin
          if (accept && drain) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d = in_entry;
          end else if (drain) begin
            main_d = '0;
          end
        end
        StFull: begin
          // in_ready is low here, so only a drain can move data.
          if (drain) begin
            main_d = skid_q;
            skid_d = '0;
          end
        end
        default: begin
          main_d = '0;
          skid_d = '0;
        end
      endcase
    end
  end

  // Entry registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count cycles where a beat waits on downstream. Reset clears the count;
  // flush does not. Wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (main_q.valid && !out_ready && !flush) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid. A scoreboard queue holds the expected beats;
// a monitor pops one and compares it on every drain. Directed checks cover
// reset, occupancy, flush and async reset.
module tb_pipe_stage_skid;

  localparam int DW = 96;
  localparam int EW = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] exc;
    logic          bd;
  } beat_t;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [EW-1:0] in_exc;
  logic          in_bd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_exc;
  logic          out_bd;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  beat_t exp_q[$];

  pipe_stage_skid #(
    .DATA_W(DW),
    .EXC_W (EW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_exc   (in_exc),
    .in_bd    (in_bd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_exc  (out_exc),
    .out_bd   (out_bd),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus side of the scoreboard: record every accepted beat. Flush and
  // reset discard everything the stage holds.
  always @(negedge clk) begin
    if (!reset || flush) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back({in_data, in_exc, in_bd});
    end
  end

  // Monitor: each drained beat must match the oldest outstanding beat.
  always @(negedge clk) begin
    beat_t e;
    if (reset && !flush && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: got %0h, expected no beat", {out_data, out_exc, out_bd});
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_exc, out_bd} !== e) begin
          n_fail++;
          $display("FAIL scoreboard: got %0h, expected %0h", {out_data, out_exc, out_bd}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_exc    = '0;
    in_bd     = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset occupancy", 128'(occupancy), 128'd0);
    check("reset in_ready", 128'(in_ready), 128'd1);
    check("reset out_data", 128'(out_data), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Streaming: one beat per cycle with one cycle of latency.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
      check("stream out_valid", 128'(out_valid), 128'd1);
      check("stream out_data", 128'(out_data), 128'(i));
      check("stream occupancy", 128'(occupancy), 128'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream drained", 128'(occupancy), 128'd0);

    // Backpressure: A and B are held, C waits upstream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('hA);
    step();
    in_data = DW'('hB);
    step();
    check("bp occupancy", 128'(occupancy), 128'd2);
    check("bp in_ready", 128'(in_ready), 128'd0);
    in_data = DW'('hC);
    step();
    check("bp hold occupancy", 128'(occupancy), 128'd2);
    check("bp stable out_data", 128'(out_data), 128'hA);
    out_ready = 1'b1;
    step();
    check("bp after drain A", 128'(out_data), 128'hB);
    step();
    check("bp C arrives", 128'(out_data), 128'hC);
    in_valid = 1'b0;
    step();
    check("bp empty", 128'(occupancy), 128'd0);

    // Exception and delay-slot fields travel with their payload.
    in_valid = 1'b1;
    in_data  = DW'('h1234);
    in_exc   = 5'd10;
    in_bd    = 1'b1;
    step();
    in_valid = 1'b0;
    in_exc   = '0;
    in_bd    = 1'b0;
    check("exc out_exc", 128'(out_exc), 128'd10);
    check("exc out_bd", 128'(out_bd), 128'd1);
    check("exc out_data", 128'(out_data), 128'h1234);
    step();

    // Flush while FULL: the stage empties and the flush-cycle input is dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('h11);
    step();
    in_data = DW'('h22);
    step();
    check("flush pre occupancy", 128'(occupancy), 128'd2);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = DW'('h33);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", 128'(out_valid), 128'd0);
    check("flush occupancy", 128'(occupancy), 128'd0);
    check("flush out_data", 128'(out_data), 128'd0);
    check("flush in_ready", 128'(in_ready), 128'd1);
    step();
    check("flush input dropped", 128'(out_valid), 128'd0);

    // Flush held for several cycles keeps the stage empty despite in_valid.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'('h44);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush hold occupancy", 128'(occupancy), 128'd0);
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    step();

    // Asynchronous reset between edges while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('h55);
    step();
    in_data = DW'('h66);
    step();
    in_valid = 1'b0;
    check("areset pre occupancy", 128'(occupancy), 128'd2);
    #2;
    reset = 1'b0;
    #1;
    check("areset out_valid", 128'(out_valid), 128'd0);
    check("areset in_ready", 128'(in_ready), 128'd1);
    check("areset occupancy", 128'(occupancy), 128'd0);
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = DW'('h77);
    step();
    in_valid = 1'b0;
    check("post-reset out_data", 128'(out_data), 128'h77);
    check("post-reset occupancy", 128'(occupancy), 128'd1);
    step();
    check("post-reset drained", 128'(occupancy), 128'd0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Three stalled cycles, then a flush that must not touch the count.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('h88);
    step();
    in_valid = 1'b0;
    check("stall start", 128'(stall_cnt), 128'd0);
    for (int i = 0; i < 3; i++) step();
    check("stall count", 128'(stall_cnt), 128'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("stall after flush", 128'(stall_cnt), 128'd3);
`endif

    out_ready = 1'b1;
    repeat (3) step();
    check("scoreboard empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
